// File: rtl/lfsr_checker_pkg.sv
// lfsr_checker_pkg: shared state enum, LFSR next-value function and error-count ceiling.
package lfsr_checker_pkg;
  typedef enum logic {SEARCH, LOCKED} state_e;
  localparam logic [7:0] ERR_MAX = 8'd255;
  function automatic logic [2:0] nxt(input logic [2:0] x);
    return {x[1], x[0], x[2] ^ x[1]};
  endfunction
endpackage

// File: rtl/lfsr_checker_predict.sv
// lfsr_predict: 3-bit predictor register, loads nxt(d_i) or advances itself.
module lfsr_predict
  import lfsr_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);
  logic [2:0] q_q, q_d;
  always_comb q_d = load_i ? nxt(d_i) : adv_i ? nxt(q_q) : q_q;
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 3'd0;
    else q_q <= q_d;
  end
  assign q_o = q_q;
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: tracks a 3-bit game-engine LFSR, declares lock and counts mismatches.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [2:0] data_in,
  output logic       locked,
  output logic [2:0] expected,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic       zero_seen
);
  localparam logic [2:0] LOCK_N = LOCK_COUNT[2:0];
  localparam logic [2:0] LOSS_N = LOSS_LIMIT[2:0];
  state_e state_q, state_d;
  logic [2:0] match_q, match_d, miss_q, miss_d;
  logic seed_q, seed_d, pulse_d, zero_d;
  logic [7:0] cnt_d;
  logic hit, bad;
  lfsr_predict u_pred (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(clk_en && state_q == SEARCH),
    .adv_i (clk_en && state_q == LOCKED),
    .d_i   (data_in),
    .q_o   (expected)
  );
  assign bad = data_in != expected;
  // the seeding sample only primes the predictor, so it can never be a hit
  assign hit = !bad && data_in != 3'd0 && !seed_q;
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    seed_d  = seed_q;
    pulse_d = 1'b0;
    cnt_d   = err_count;
    zero_d  = zero_seen | (clk_en && data_in == 3'd0);
    if (clk_en && state_q == SEARCH) begin
      seed_d  = 1'b0;
      match_d = hit ? match_q + 3'd1 : 3'd0;
      if (hit && match_q + 3'd1 == LOCK_N) begin
        state_d = LOCKED;
        match_d = 3'd0;
        miss_d  = 3'd0;
      end
    end else if (clk_en && bad) begin
      pulse_d = 1'b1;
      cnt_d   = err_count == ERR_MAX ? err_count : err_count + 8'd1;
      miss_d  = miss_q + 3'd1;
      if (miss_q + 3'd1 == LOSS_N) begin
        state_d = SEARCH;
        miss_d  = 3'd0;
        match_d = 3'd0;
        seed_d  = 1'b1;
      end
    end else if (clk_en) miss_d = 3'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      match_q   <= 3'd0;
      miss_q    <= 3'd0;
      seed_q    <= 1'b1;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
      zero_seen <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      seed_q    <= seed_d;
      locked    <= state_d == LOCKED;
      err_pulse <= pulse_d;
      err_count <= cnt_d;
      zero_seen <= zero_d;
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed plus random stimulus against a behavioural scoreboard model.
module tb_lfsr_checker;
  localparam int LOCK = 3;
  localparam int LOSS = 2;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic [2:0] data_in = 3'd0, expected;
  logic locked, err_pulse, zero_seen;
  logic [7:0] err_count;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic       lock;
    logic [2:0] exp;
    logic       pulse;
    logic [7:0] cnt;
    logic       zero;
  } exp_t;
  exp_t sb[$];
  bit m_lock, m_seed, m_pulse, m_zero;
  int m_match, m_miss, m_cnt;
  logic [2:0] m_exp;

  lfsr_checker #(.LOCK_COUNT(LOCK), .LOSS_LIMIT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data_in(data_in),
    .locked(locked), .expected(expected), .err_pulse(err_pulse),
    .err_count(err_count), .zero_seen(zero_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] nx(input logic [2:0] x);
    logic [2:0] r;
    r = x << 1;
    r[0] = x[2] ^ x[1];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic step(input bit rn, input bit en, input logic [2:0] d);
    exp_t e;
    rst_n = rn;
    clk_en = en;
    data_in = d;
    if (!rn) begin
      m_lock = 0; m_seed = 1; m_pulse = 0; m_zero = 0;
      m_match = 0; m_miss = 0; m_cnt = 0; m_exp = 3'd0;
    end else begin
      m_pulse = 0;
      if (en) begin
        if (d == 3'd0) m_zero = 1;
        if (!m_lock) begin
          if (m_seed) begin
            m_seed = 0;
            m_match = 0;
          end else if (d == m_exp && d != 3'd0) m_match++;
          else m_match = 0;
          m_exp = nx(d);
          if (m_match == LOCK) begin
            m_lock = 1; m_match = 0; m_miss = 0;
          end
        end else begin
          if (d != m_exp) begin
            m_pulse = 1;
            if (m_cnt < 255) m_cnt++;
            m_miss++;
            if (m_miss == LOSS) begin
              m_lock = 0; m_miss = 0; m_match = 0; m_seed = 1;
            end
          end else m_miss = 0;
          m_exp = nx(m_exp);
        end
      end
    end
    sb.push_back('{m_lock, m_exp, m_pulse, m_cnt[7:0], m_zero});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked", {7'd0, locked}, {7'd0, e.lock});
    chk("expected", {5'd0, expected}, {5'd0, e.exp});
    chk("err_pulse", {7'd0, err_pulse}, {7'd0, e.pulse});
    chk("err_count", err_count, e.cnt);
    chk("zero_seen", {7'd0, zero_seen}, {7'd0, e.zero});
  endtask

  task automatic lock_from(input logic [2:0] v);
    logic [2:0] d;
    d = v;
    repeat (4) begin
      step(1, 1, d);
      d = nx(d);
    end
  endtask

  task automatic two_bad();
    repeat (2) step(1, 1, m_exp ^ 3'b001);
  endtask

  initial begin
    step(0, 0, 3'd0);
    step(0, 1, 3'd5);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_expected", {5'd0, expected}, 8'd0);
    chk("rst_count", err_count, 8'd0);
    step(1, 1, 3'b001);
    step(1, 1, 3'b010);
    step(1, 1, 3'b101);
    chk("not_yet_locked", {7'd0, locked}, 8'd0);
    step(1, 1, 3'b011);
    chk("lock_rise", {7'd0, locked}, 8'd1);
    chk("lock_pred", {5'd0, expected}, 8'b111);
    chk("lock_errs", err_count, 8'd0);
    step(1, 1, 3'b111);
    step(1, 1, 3'b000);
    chk("bad_pulse", {7'd0, err_pulse}, 8'd1);
    step(1, 1, 3'b100);
    chk("zero_sticky", {7'd0, zero_seen}, 8'd1);
    chk("one_err", err_count, 8'd1);
    chk("still_locked", {7'd0, locked}, 8'd1);
    chk("pulse_one_cycle", {7'd0, err_pulse}, 8'd0);
    repeat (10) step(1, 0, 3'($urandom_range(7)));
    chk("idle_locked", {7'd0, locked}, 8'd1);
    chk("idle_pred", {5'd0, expected}, 8'b001);
    repeat (4) step(1, 1, m_exp);
    chk("idle_no_err", err_count, 8'd1);
    two_bad();
    chk("loss", {7'd0, locked}, 8'd0);
    chk("loss_errs", err_count, 8'd3);
    lock_from(3'b110);
    chk("relock", {7'd0, locked}, 8'd1);
    step(0, 1, m_exp);
    chk("midrst_locked", {7'd0, locked}, 8'd0);
    chk("midrst_pulse", {7'd0, err_pulse}, 8'd0);
    chk("midrst_count", err_count, 8'd0);
    chk("midrst_zero", {7'd0, zero_seen}, 8'd0);
    repeat (10) step(1, 1, 3'd0);
    chk("zeros_unlocked", {7'd0, locked}, 8'd0);
    chk("zeros_seen", {7'd0, zero_seen}, 8'd1);
    chk("zeros_errs", err_count, 8'd0);
    step(0, 0, 3'd0);
    repeat (150) begin
      lock_from(3'b001);
      two_bad();
    end
    chk("sat", err_count, 8'd255);
    lock_from(3'b100);
    two_bad();
    chk("sat_hold", err_count, 8'd255);
    step(0, 0, 3'd0);
    repeat (300) step(1, 1'($urandom_range(1)), ($urandom_range(3) == 0) ? m_exp ^ 3'($urandom_range(7)) : m_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
